// File: rtl/threshold_if.sv
// Key-pulse / level / threshold bundle between the key debouncers, the
// threshold_setter and the display/buzzer stage.
interface threshold_if #(
  parameter int unsigned WIDTH = 7
);
  logic             key_mode;
  logic             key_up;
  logic             key_down;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] threshold;
  logic [WIDTH-1:0] disp_value;
  logic             editing;
  logic             alarm;

  modport master (
    output key_mode, key_up, key_down, level,
    input  threshold, disp_value, editing, alarm
  );

  modport slave (
    input  key_mode, key_up, key_down, level,
    output threshold, disp_value, editing, alarm
  );
endinterface

// File: rtl/threshold_setter.sv
// Alarm-threshold entry controller: MODE/UP/DOWN edit a shadow value that MODE
// commits; idle edits time out. Define THRESHOLD_WRAP_EN for wrap-around editing.
module threshold_setter #(
  parameter int unsigned WIDTH          = 7,
  parameter int unsigned TH_MIN         = 0,
  parameter int unsigned TH_MAX         = 99,
  parameter int unsigned TH_DEFAULT     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  threshold_if.slave  bus
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(TH_MIN);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(TH_MAX);
  localparam logic [WIDTH-1:0] DEF_V  = WIDTH'(TH_DEFAULT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    EDIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] threshold_q, threshold_d;
  logic [WIDTH-1:0] disp_q, disp_d;
  logic             editing_q, editing_d;
  logic             alarm_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [WIDTH-1:0] shadow_inc;
  logic [WIDTH-1:0] shadow_dec;
  logic             any_key;

  // Bounded step values; shadow is kept inside [MIN_V, MAX_V] so equality
  // at the limits is sufficient.
  always_comb begin
`ifdef THRESHOLD_WRAP_EN
    shadow_inc = (shadow_q == MAX_V) ? MIN_V : shadow_q + ONE_V;
    shadow_dec = (shadow_q == MIN_V) ? MAX_V : shadow_q - ONE_V;
`else
    shadow_inc = (shadow_q == MAX_V) ? MAX_V : shadow_q + ONE_V;
    shadow_dec = (shadow_q == MIN_V) ? MIN_V : shadow_q - ONE_V;
`endif
  end

  assign any_key = bus.key_mode | bus.key_up | bus.key_down;

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state_q;
    shadow_d    = shadow_q;
    threshold_d = threshold_q;
    cnt_d       = cnt_q;

    case (state_q)
      RUN: begin
        if (bus.key_mode) begin
          state_d  = EDIT;
          shadow_d = threshold_q;
          cnt_d    = '0;
        end
      end

      EDIT: begin
        if (any_key) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end

        if (bus.key_mode) begin
          state_d     = RUN;
          threshold_d = shadow_q;
        end else if (bus.key_up && !bus.key_down) begin
          shadow_d = shadow_inc;
        end else if (bus.key_down && !bus.key_up) begin
          shadow_d = shadow_dec;
        end
      end

      default: begin
        state_d = RUN;
      end
    endcase

    editing_d = (state_d == EDIT);
    disp_d    = (state_d == EDIT) ? shadow_d : threshold_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      shadow_q    <= DEF_V;
      threshold_q <= DEF_V;
      disp_q      <= DEF_V;
      editing_q   <= 1'b0;
      alarm_q     <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      threshold_q <= threshold_d;
      disp_q      <= disp_d;
      editing_q   <= editing_d;
      alarm_q     <= (bus.level >= threshold_q);
      cnt_q       <= cnt_d;
    end
  end

  assign bus.threshold  = threshold_q;
  assign bus.disp_value = disp_q;
  assign bus.editing    = editing_q;
  assign bus.alarm      = alarm_q;

endmodule

// File: tb/tb_threshold_setter.sv
// Randomized bench for threshold_setter against a behavioural model of the
// edit/commit/timeout rules, plus directed literal checks.
module tb_threshold_setter;

  localparam int TO     = 16;
  localparam int TH_LO  = 0;
  localparam int TH_HI  = 99;
  localparam int TH_DEF = 50;

  logic clk;
  logic rst;

  threshold_if #(.WIDTH(7)) bus ();

  threshold_setter #(
    .WIDTH(7), .TH_MIN(TH_LO), .TH_MAX(TH_HI), .TH_DEFAULT(TH_DEF),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural model state
  bit m_edit;
  int m_sh, m_thr, m_idle, m_old_thr;
  bit m_alarm;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic int step_up(input int v);
`ifdef THRESHOLD_WRAP_EN
    return (v >= TH_HI) ? TH_LO : v + 1;
`else
    return (v >= TH_HI) ? TH_HI : v + 1;
`endif
  endfunction

  function automatic int step_dn(input int v);
`ifdef THRESHOLD_WRAP_EN
    return (v <= TH_LO) ? TH_HI : v - 1;
`else
    return (v <= TH_LO) ? TH_LO : v - 1;
`endif
  endfunction

  // Reference model: applies the rules to the inputs seen at each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_edit = 0; m_sh = TH_DEF; m_thr = TH_DEF; m_idle = 0; m_alarm = 0;
    end else begin
      m_old_thr = m_thr;
      if (!m_edit) begin
        if (bus.key_mode) begin
          m_edit = 1; m_sh = m_thr; m_idle = 0;
        end
      end else if (bus.key_mode) begin
        m_thr = m_sh; m_edit = 0;
      end else if (bus.key_up || bus.key_down) begin
        m_idle = 0;
        if (bus.key_up && !bus.key_down) m_sh = step_up(m_sh);
        else if (bus.key_down && !bus.key_up) m_sh = step_dn(m_sh);
      end else begin
        m_idle++;
        if (m_idle >= TO) m_edit = 0;
      end
      m_alarm = (int'(bus.level) >= m_old_thr);
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge clk) begin
    if (rst) begin
      chk("threshold", int'(bus.threshold), m_thr);
      chk("disp_value", int'(bus.disp_value), m_edit ? m_sh : m_thr);
      chk("editing", int'(bus.editing), int'(m_edit));
      chk("alarm", int'(bus.alarm), int'(m_alarm));
    end
  end

  task automatic cyc(input bit m, input bit u, input bit d);
    bus.key_mode = m; bus.key_up = u; bus.key_down = d;
    @(posedge clk); #2;
    bus.key_mode = 0; bus.key_up = 0; bus.key_down = 0;
  endtask

  int exp_sat;

  initial begin
`ifdef THRESHOLD_WRAP_EN
    exp_sat = 10;
`else
    exp_sat = 99;
`endif
    rst = 1'b0;
    bus.key_mode = 0; bus.key_up = 0; bus.key_down = 0;
    bus.level = 7'd60;
    #22 rst = 1'b1;
    @(posedge clk); #2;
    @(posedge clk); #2;
    chk("lit_reset_threshold", int'(bus.threshold), 50);
    chk("lit_reset_editing", int'(bus.editing), 0);
    chk("lit_reset_alarm", int'(bus.alarm), 1);
    chk("lit_reset_disp", int'(bus.disp_value), 50);

    // MODE, UP x3, MODE with level 52
    bus.level = 7'd52;
    cyc(1, 0, 0);
    chk("lit_enter_editing", int'(bus.editing), 1);
    repeat (3) cyc(0, 1, 0);
    chk("lit_edit_disp", int'(bus.disp_value), 53);
    chk("lit_edit_thr_unchanged", int'(bus.threshold), 50);
    cyc(1, 0, 0);
    chk("lit_commit_thr", int'(bus.threshold), 53);
    chk("lit_commit_editing", int'(bus.editing), 0);
    chk("lit_commit_alarm_old", int'(bus.alarm), 1);
    cyc(0, 0, 0);
    chk("lit_commit_alarm_new", int'(bus.alarm), 0);

    // back to 50, then saturate / wrap
    cyc(1, 0, 0); repeat (3) cyc(0, 0, 1); cyc(1, 0, 0);
    chk("lit_back_to_50", int'(bus.threshold), 50);
    cyc(1, 0, 0);
    repeat (60) cyc(0, 1, 0);
    chk("lit_up60_disp", int'(bus.disp_value), exp_sat);

    // MODE+UP commits without increment
    cyc(1, 1, 0);
    chk("lit_mode_up_thr", int'(bus.threshold), exp_sat);
    chk("lit_mode_up_editing", int'(bus.editing), 0);

    // UP+DOWN together is ignored
    cyc(1, 0, 0);
    cyc(0, 1, 1);
    chk("lit_up_down_disp", int'(bus.disp_value), exp_sat);

    // Timeout after 16 idle cycles discards the edit
    repeat (2) cyc(0, 0, 1);
    repeat (TO - 1) cyc(0, 0, 0);
    chk("lit_timeout_still_editing", int'(bus.editing), 1);
    cyc(0, 0, 0);
    chk("lit_timeout_editing", int'(bus.editing), 0);
    chk("lit_timeout_thr", int'(bus.threshold), exp_sat);
    chk("lit_timeout_disp", int'(bus.disp_value), exp_sat);

    // Asynchronous reset mid-edit
    cyc(1, 0, 0);
    repeat (7) cyc(0, 0, 1);
    #1 rst = 1'b0;
    #1;
    chk("lit_async_editing", int'(bus.editing), 0);
    chk("lit_async_thr", int'(bus.threshold), 50);
    chk("lit_async_disp", int'(bus.disp_value), 50);
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #2;

    // Randomized traffic with periodic quiet windows to reach the timeout
    for (int i = 0; i < 3000; i++) begin
      bit m, u, d;
      if (($urandom % 8) == 0) bus.level = 7'($urandom % 128);
      if ((i % 200) > 170) begin
        m = 0; u = 0; d = 0;
      end else begin
        m = (($urandom % 10) == 0);
        u = (($urandom % 4) == 0);
        d = (($urandom % 5) == 0);
      end
      cyc(m, u, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
